// File: rtl/mercury_mem_pkg.sv
// Shared types for the mercury memory-port arbiter: default widths, FSM states,
// transaction owner and the request record that is held while a transaction is in flight.
package mercury_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } mem_owner_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]   addr;
        logic                    we;
        logic [DEF_DATA_W-1:0]   wdata;
        logic [DEF_DATA_W/8-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/mercury_mem_arbiter.sv
// Single-outstanding arbiter sharing the mercury memory port between IFU and LSU.
// LSU has priority; a saturating counter lets a waiting IFU through after STARVE_LIMIT LSU grants.
module mercury_mem_arbiter
    import mercury_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_we,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wstrb,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_data,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_we,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data
);

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic                we;
        logic [DATA_W-1:0]   wdata;
        logic [DATA_W/8-1:0] wstrb;
    } req_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e state;
    mem_owner_e owner;
    req_t       req_q;
    logic [3:0] starve_cnt;

    logic lsu_win;
    logic ifu_win;
    logic rsp_fire;

    // Grants are suppressed while rst is high so nothing is accepted and then dropped.
    always_comb begin
        lsu_win = 1'b0;
        ifu_win = 1'b0;
        if (state == IDLE && !rst) begin
            if (lsu_req_valid && !(starve_cnt == LIMIT && ifu_req_valid))
                lsu_win = 1'b1;
            else if (ifu_req_valid)
                ifu_win = 1'b1;
        end
    end

    assign ifu_req_ready = ifu_win;
    assign lsu_req_ready = lsu_win;

    assign mem_req_valid = (state == ISSUE);
    assign mem_req_addr  = req_q.addr;
    assign mem_req_we    = req_q.we;
    assign mem_req_wdata = req_q.wdata;
    assign mem_req_wstrb = req_q.wstrb;

    // Responses outside WAIT are protocol violations and are dropped here.
    assign rsp_fire      = (state == WAIT) && mem_rsp_valid && !rst;
    assign ifu_rsp_valid = rsp_fire && (owner == OWN_IFU);
    assign lsu_rsp_valid = rsp_fire && (owner == OWN_LSU);
    assign ifu_rsp_data  = ifu_rsp_valid ? mem_rsp_data : '0;
    assign lsu_rsp_data  = (lsu_rsp_valid && !req_q.we) ? mem_rsp_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_IFU;
            req_q      <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_win) begin
                        req_q.addr  <= lsu_req_addr;
                        req_q.we    <= lsu_req_we;
                        req_q.wdata <= lsu_req_wdata;
                        req_q.wstrb <= lsu_req_wstrb;
                        owner       <= OWN_LSU;
                        state       <= ISSUE;
                        if (!ifu_req_valid)
                            starve_cnt <= '0;
                        else if (starve_cnt != LIMIT)
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (ifu_win) begin
                        req_q.addr  <= ifu_req_addr;
                        req_q.we    <= 1'b0;
                        req_q.wdata <= '0;
                        req_q.wstrb <= '0;
                        owner       <= OWN_IFU;
                        state       <= ISSUE;
                        starve_cnt  <= '0;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready)
                        state <= WAIT;
                end
                WAIT: begin
                    if (mem_rsp_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mercury_mem_arbiter.sv
// Directed bench for mercury_mem_arbiter: inputs change 1ns after the rising edge,
// outputs are checked 2ns after it, well clear of the next edge.
module tb_mercury_mem_arbiter;
    import mercury_mem_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [AW-1:0] ifu_req_addr;
    logic [DW-1:0] ifu_rsp_data;
    logic          lsu_req_valid, lsu_req_ready, lsu_req_we, lsu_rsp_valid;
    logic [AW-1:0] lsu_req_addr;
    logic [DW-1:0] lsu_req_wdata, lsu_rsp_data;
    logic [3:0]    lsu_req_wstrb;
    logic          mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata, mem_rsp_data;
    logic [3:0]    mem_req_wstrb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mercury_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_addr(lsu_req_addr), .lsu_req_we(lsu_req_we),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // All outputs packed together so one compare covers "everything is zero".
    function automatic logic [63:0] out_or();
        return 64'(ifu_req_ready | lsu_req_ready | ifu_rsp_valid | lsu_rsp_valid | mem_req_valid)
             | 64'(ifu_rsp_data | lsu_rsp_data | mem_req_addr | mem_req_wdata)
             | 64'(mem_req_we) | 64'(mem_req_wstrb);
    endfunction

    // Called in the ISSUE cycle: memory accepts at once, answers with d one cycle later.
    task automatic serve(input string tag, input logic to_lsu, input logic [DW-1:0] d,
                         input logic [DW-1:0] exp_data);
        mem_req_ready = 1'b1;
        #1;
        chk({tag, ".mem_valid"}, 64'(mem_req_valid), 64'd1);
        cyc();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = d;
        #1;
        chk({tag, ".rsp_valid"}, {62'd0, ifu_rsp_valid, lsu_rsp_valid}, to_lsu ? 64'd1 : 64'd2);
        chk({tag, ".rsp_data"}, 64'(to_lsu ? lsu_rsp_data : ifu_rsp_data), 64'(exp_data));
        chk({tag, ".other_data"}, 64'(to_lsu ? ifu_rsp_data : lsu_rsp_data), 64'd0);
        chk({tag, ".no_accept"}, {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
        cyc();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_valid = 0; ifu_req_addr = '0;
        lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_we = 0; lsu_req_wdata = '0; lsu_req_wstrb = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
        cyc(); cyc();
        #1;
        chk("reset.outputs", out_or(), 64'd0);
        chk("reset.state", 64'(dut.state), 64'(IDLE));
        chk("reset.starve", 64'(dut.starve_cnt), 64'd0);
        rst = 1'b0;

        // Single IFU read; accept, ISSUE, WAIT: response lands in the 3rd cycle counting the accept.
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h100;
        #1;
        chk("ifu.ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd2);
        cyc();
        ifu_req_valid = 1'b0;
        #1;
        chk("ifu.mem_req", {mem_req_addr, 27'd0, mem_req_we, mem_req_wstrb}, {32'h100, 32'd0});
        serve("ifu", 1'b0, 32'hDEADBEEF, 32'hDEADBEEF);
        chk("ifu.pulse_end", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
        chk("ifu.idle", 64'(dut.state), 64'(IDLE));

        // Contention: LSU first, IFU only after the LSU response.
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h200;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h40; lsu_req_we = 1'b0;
        #1;
        chk("cont.grant1", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd1);
        cyc();
        lsu_req_valid = 1'b0;
        #1;
        chk("cont.issue_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
        chk("cont.addr", 64'(mem_req_addr), 64'h40);
        chk("cont.starve1", 64'(dut.starve_cnt), 64'd1);
        serve("cont.lsu", 1'b1, 32'h0000A5A5, 32'h0000A5A5);
        #1;
        chk("cont.grant2", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd2);
        cyc();
        ifu_req_valid = 1'b0;
        #1;
        chk("cont.starve_clr", 64'(dut.starve_cnt), 64'd0);
        serve("cont.ifu", 1'b0, 32'h11112222, 32'h11112222);

        // Starvation: IFU held valid against a stream of LSU reads.
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h300;
        lsu_req_valid = 1'b1; lsu_req_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lsu_req_addr = 32'h1000 + 32'(i * 4);
            #1;
            chk($sformatf("starve.lsu%0d", i), {62'd0, ifu_req_ready, lsu_req_ready}, 64'd1);
            cyc();
            chk($sformatf("starve.addr%0d", i), 64'(mem_req_addr), 64'h1000 + 64'(i * 4));
            serve($sformatf("starve.rsp%0d", i), 1'b1, 32'hC0DE0000 + 32'(i), 32'hC0DE0000 + 32'(i));
        end
        chk("starve.sat", 64'(dut.starve_cnt), 64'd4);
        #1;
        chk("starve.ifu_wins", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd2);
        cyc();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        #1;
        chk("starve.clr", 64'(dut.starve_cnt), 64'd0);
        chk("starve.ifu_addr", 64'(mem_req_addr), 64'h300);
        serve("starve.ifu", 1'b0, 32'h0BADF00D, 32'h0BADF00D);

        // Memory stall on an LSU write: fields must hold while mem_req_ready is low.
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h20; lsu_req_we = 1'b1;
        lsu_req_wdata = 32'h12345678; lsu_req_wstrb = 4'hF;
        cyc();
        lsu_req_valid = 1'b0; lsu_req_addr = 32'hFFFF; lsu_req_wdata = '0; lsu_req_wstrb = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("stall.fields%0d", i),
                {mem_req_valid, mem_req_we, mem_req_wstrb, 26'(mem_req_addr), mem_req_wdata},
                {1'b1, 1'b1, 4'hF, 26'h20, 32'h12345678});
            cyc();
        end
        serve("stall.ack", 1'b1, 32'hFFFFFFFF, 32'h0);

        // Reset in WAIT, then a stray response.
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h80; lsu_req_we = 1'b0;
        cyc();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        chk("rst.in_wait", 64'(dut.state), 64'(WAIT));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rst.outputs", out_or(), 64'd0);
        chk("rst.state", 64'(dut.state), 64'(IDLE));
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55AA55AA;
        #1;
        chk("rst.stray", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
        cyc();
        mem_rsp_valid = 1'b0;
        chk("rst.stray_state", 64'(dut.state), 64'(IDLE));

        // Spurious response in ISSUE.
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h400;
        cyc();
        ifu_req_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h77777777;
        #1;
        chk("spur.issue_rsp", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
        cyc();
        mem_rsp_valid = 1'b0;
        chk("spur.issue_state", 64'(dut.state), 64'(ISSUE));
        serve("spur.finish", 1'b0, 32'h00C0FFEE, 32'h00C0FFEE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
